// File: rtl/led_frame_sched.sv
// Frame scheduler: buffers writer frames and launches one to the LED PHY per refresh tick.
// Latency: a launch is decided in the tick (or phy_busy release) cycle; enable/data_in follow one cycle later.
// Backpressure: wr_ready is !full with no same-cycle bypass; launches are deferred while phy_busy is high.
module led_frame_sched #(
  parameter int DATA_W      = 128,
  parameter int PERIOD_CYC  = 25000,
  parameter int FIFO_DEPTH  = 2,
  parameter int REPEAT_LAST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              phy_busy,
  output logic              enable,
  output logic [DATA_W-1:0] data_in,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       late_cnt
);

  localparam int CNT_W = $clog2(PERIOD_CYC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, WAIT_PHY, LAUNCH} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   tmr_cnt;
  logic               tick;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full, empty, wr_fire, pop;
  logic               go_launch, late_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Refresh timer: cleared while stopped so the first tick lands PERIOD_CYC cycles after run rises.
  assign tick = run && (tmr_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt <= '0;
    end else if (!run || tick) begin
      tmr_cnt <= '0;
    end else begin
      tmr_cnt <= tmr_cnt + CNT_W'(1);
    end
  end

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full;
  assign pop      = go_launch && !empty;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (run) next_state = WAIT_TICK;
      WAIT_TICK: begin
        if (!run)      next_state = IDLE;
        else if (tick) next_state = phy_busy ? WAIT_PHY : LAUNCH;
      end
      WAIT_PHY: begin
        if (!run)          next_state = IDLE;
        else if (!phy_busy) next_state = LAUNCH;
      end
      LAUNCH:    next_state = run ? WAIT_TICK : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // A tick arriving while already owed a launch is folded into that launch.
  always_comb begin
    go_launch = 1'b0;
    late_inc  = 1'b0;
    if (next_state == LAUNCH && state != LAUNCH) go_launch = 1'b1;
    if (state == WAIT_PHY && tick)               late_inc  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable       <= 1'b0;
      data_in      <= '0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else begin
      enable <= 1'b0;
      if (go_launch) begin
        if (!empty) begin
          enable    <= 1'b1;
          data_in   <= mem[rd_ptr];
          frame_cnt <= sat_inc(frame_cnt);
        end else begin
          enable       <= (REPEAT_LAST != 0);
          underrun_cnt <= sat_inc(underrun_cnt);
        end
      end
      if (late_inc) late_cnt <= sat_inc(late_cnt);
    end
  end

endmodule

// File: tb/tb_led_frame_sched.sv
// Randomized bench for led_frame_sched: a rule-level model feeds launch scoreboards for both REPEAT_LAST settings.
module tb_led_frame_sched;

  localparam int DW = 128;
  localparam int P  = 8;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          wr_valid = 1'b0;
  logic          phy_busy = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic          rdy_r, en_r, rdy_s, en_s;
  logic [DW-1:0] din_r, din_s;
  logic [15:0]   fc_r, uc_r, lc_r, fc_s, uc_s, lc_s;

  led_frame_sched #(.DATA_W(DW), .PERIOD_CYC(P), .FIFO_DEPTH(D), .REPEAT_LAST(1)) u_dut_rep (
    .clk(clk), .rst(rst), .run(run), .wr_valid(wr_valid), .wr_ready(rdy_r), .wr_data(wr_data),
    .phy_busy(phy_busy), .enable(en_r), .data_in(din_r),
    .frame_cnt(fc_r), .underrun_cnt(uc_r), .late_cnt(lc_r));

  led_frame_sched #(.DATA_W(DW), .PERIOD_CYC(P), .FIFO_DEPTH(D), .REPEAT_LAST(0)) u_dut_skip (
    .clk(clk), .rst(rst), .run(run), .wr_valid(wr_valid), .wr_ready(rdy_s), .wr_data(wr_data),
    .phy_busy(phy_busy), .enable(en_s), .data_in(din_s),
    .frame_cnt(fc_s), .underrun_cnt(uc_s), .late_cnt(lc_s));

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          sb_r[$];
  exp_t          sb_s[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_frame = '0;
  int            cyc = 0, mcnt = 0;
  bit            armed = 0, owed = 0, launching = 0, wr_taken = 0;
  int            m_frames = 0, m_under = 0, m_late = 0;
  int            errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_enable_rep"}, en_r, 0);
    chk({tag, "_enable_skip"}, en_s, 0);
    chk({tag, "_data_in"}, din_r, 0);
    chk({tag, "_wr_ready"}, rdy_r, 1);
    chk({tag, "_frame_cnt"}, fc_r, 0);
    chk({tag, "_underrun_cnt"}, uc_r, 0);
    chk({tag, "_late_cnt"}, lc_r, 0);
  endtask

  // Reference model: rules of the scheduler expressed as "owed launch" bookkeeping plus a frame queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; mcnt = 0; armed = 0; owed = 0; launching = 0; wr_taken = 0;
      q.delete(); sb_r.delete(); sb_s.delete();
      last_frame = '0; m_frames = 0; m_under = 0; m_late = 0;
    end else begin
      bit   tick, go, take;
      exp_t e;
      cyc++;
      tick = run && (mcnt == P - 1);
      go   = 0;
      if (launching) begin
        launching = 0;
        armed = run;
      end else if (!run) begin
        armed = 0;
        owed  = 0;
      end else if (!armed) begin
        armed = 1;
      end else begin
        if (tick) begin
          if (owed) m_late++;
          owed = 1;
        end
        if (owed && !phy_busy) begin
          go   = 1;
          owed = 0;
        end
      end
      take = wr_valid && (q.size() < D);
      if (go) begin
        launching = 1;
        e.cyc = cyc;
        if (q.size() > 0) begin
          last_frame = q.pop_front();
          m_frames++;
          e.dat = last_frame;
          sb_r.push_back(e);
          sb_s.push_back(e);
        end else begin
          m_under++;
          e.dat = last_frame;
          sb_r.push_back(e);
        end
      end
      if (take) q.push_back(wr_data);
      wr_taken = take;
      mcnt = (!run || tick) ? 0 : mcnt + 1;
    end
  end

  // Monitor: every DUT launch must match the head of its scoreboard, in data and in cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("wr_ready_rep", rdy_r, q.size() < D);
      chk("wr_ready_skip", rdy_s, q.size() < D);
      if (en_r) begin
        if (sb_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_enable_rep: got enable=1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_r.pop_front();
          chk("launch_cycle_rep", cyc, e.cyc);
          chk("launch_data_rep", din_r, e.dat);
        end
      end else if (sb_r.size() > 0 && sb_r[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL missed_enable_rep: got enable=0, expected 1 (cycle %0d)", cyc);
        void'(sb_r.pop_front());
      end
      if (en_s) begin
        if (sb_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_enable_skip: got enable=1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_s.pop_front();
          chk("launch_cycle_skip", cyc, e.cyc);
          chk("launch_data_skip", din_s, e.dat);
        end
      end else if (sb_s.size() > 0 && sb_s[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL missed_enable_skip: got enable=0, expected 1 (cycle %0d)", cyc);
        void'(sb_s.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] frame_a, frame_b;
    frame_a = {4{32'hA5A5_0001}};
    frame_b = {4{32'h5A5A_0002}};
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Two frames A,B with the PHY idle: launches 8 and 16 cycles after run rises.
    @(negedge clk);
    run = 1'b1; wr_valid = 1'b1; wr_data = frame_a;
    @(negedge clk);
    wr_data = frame_b;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("ab_frame_cnt", fc_r, 2);
    chk("ab_data_in", din_r, frame_b);
    chk("ab_underrun_cnt", uc_r, 0);
    // Empty buffer for two more ticks: repeat instance re-sends B, skip instance stays quiet.
    repeat (16) @(negedge clk);
    chk("underrun_cnt_rep", uc_r, 2);
    chk("underrun_cnt_skip", uc_s, 2);
    chk("repeat_data_in", din_r, frame_b);

    for (int s = 0; s < 60; s++) begin
      int len, bmode, wprob;
      bit r;
      len   = $urandom_range(6, 30);
      bmode = $urandom_range(0, 3);
      wprob = $urandom_range(0, 100);
      r     = ($urandom_range(0, 5) != 0);
      if (s == 30) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
      end
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        run = r;
        case (bmode)
          0:       phy_busy = 1'b0;
          1:       phy_busy = ($urandom_range(0, 2) == 0);
          2:       phy_busy = 1'b1;
          default: phy_busy = (k < len - 3);
        endcase
        if (!wr_valid || wr_taken) begin
          wr_valid = ($urandom_range(0, 99) < wprob);
          wr_data  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end

    @(negedge clk);
    run = 1'b0; wr_valid = 1'b0; phy_busy = 1'b0;
    repeat (12) @(negedge clk);
    chk("final_frame_cnt_rep", fc_r, m_frames);
    chk("final_underrun_cnt_rep", uc_r, m_under);
    chk("final_late_cnt_rep", lc_r, m_late);
    chk("final_frame_cnt_skip", fc_s, m_frames);
    chk("final_underrun_cnt_skip", uc_s, m_under);
    chk("final_late_cnt_skip", lc_s, m_late);
    chk("pending_launches_rep", sb_r.size(), 0);
    chk("pending_launches_skip", sb_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
